// File: rtl/z80_rom_bus_ctrl.sv
// Z80 read controller for the synchronous ROM: decode, stall, capture, hold.
// Optional reset-vector mirror at 0x0000 enabled by ROM_BOOT_OVERLAY_EN.
module z80_rom_bus_ctrl #(
  parameter int          ROM_ADDR_W  = 14,
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mreq_n,
  input  logic                  rd_n,
  input  logic [15:0]           cpu_addr,
  output logic                  rom_ena,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  input  logic [7:0]            rom_dout,
  output logic [7:0]            data_out,
  output logic                  data_oe,
  output logic                  wait_n
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_STALL = 3'd2;
  localparam logic [2:0] S_LATCH = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  localparam logic [3:0] STALL_INIT =
    (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [2:0] state;
  logic [3:0] cnt;
  logic       strobe;
  logic       base_hit;
  logic       hit;

  assign strobe   = !mreq_n && !rd_n;
  assign base_hit = strobe &&
    (cpu_addr[15:ROM_ADDR_W] == BASE_ADDR[15:ROM_ADDR_W]);

`ifdef ROM_BOOT_OVERLAY_EN
  logic boot;
  logic via_base;
  logic mirror_hit;

  assign mirror_hit = strobe && boot &&
    (cpu_addr[15:ROM_ADDR_W] == '0);
  assign hit = base_hit || mirror_hit;
`else
  assign hit = base_hit;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      rom_ena  <= 1'b0;
      rom_addr <= '0;
      data_out <= 8'h00;
      data_oe  <= 1'b0;
      wait_n   <= 1'b1;
`ifdef ROM_BOOT_OVERLAY_EN
      boot     <= 1'b1;
      via_base <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (hit) begin
            rom_addr <= cpu_addr[ROM_ADDR_W-1:0];
            rom_ena  <= 1'b1;
            wait_n   <= 1'b0;
            state    <= S_READ;
`ifdef ROM_BOOT_OVERLAY_EN
            via_base <= base_hit;
`endif
          end
        end
        S_READ: begin
          rom_ena <= 1'b0;
          if (!strobe) begin
            wait_n  <= 1'b1;
            data_oe <= 1'b0;
            state   <= S_IDLE;
          end else if (WAIT_STATES > 0) begin
            cnt   <= STALL_INIT;
            state <= S_STALL;
          end else begin
            state <= S_LATCH;
          end
        end
        S_STALL: begin
          if (!strobe) begin
            wait_n  <= 1'b1;
            data_oe <= 1'b0;
            state   <= S_IDLE;
          end else if (cnt == 4'd0) begin
            state <= S_LATCH;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_LATCH: begin
          if (!strobe) begin
            wait_n  <= 1'b1;
            data_oe <= 1'b0;
            state   <= S_IDLE;
          end else begin
            data_out <= rom_dout;
            data_oe  <= 1'b1;
            wait_n   <= 1'b1;
            state    <= S_HOLD;
`ifdef ROM_BOOT_OVERLAY_EN
            if (via_base) boot <= 1'b0;
`endif
          end
        end
        S_HOLD: begin
          // strobes must rise before another read is accepted
          if (!strobe) begin
            data_oe <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z80_rom_bus_ctrl.sv
// Directed bench for z80_rom_bus_ctrl: five configurations on one CPU bus.
// Overlay expectations follow ROM_BOOT_OVERLAY_EN.
module tb_z80_rom_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mreq_n;
  logic        rd_n;
  logic [15:0] cpu_addr;

  logic [7:0] mem [0:16383];

  logic        ena0, ena3, enaz, enaf, enac;
  logic [13:0] adr0, adr3, adrz, adrf, adrc;
  logic [7:0]  rd0, rd3, rdz, rdf, rdc;
  logic [7:0]  do0, do3, doz, dof, doc;
  logic        oe0, oe3, oez, oef, oec;
  logic        wn0, wn3, wnz, wnf, wnc;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ena0) rd0 <= mem[adr0];
    if (ena3) rd3 <= mem[adr3];
    if (enaz) rdz <= mem[adrz];
    if (enaf) rdf <= mem[adrf];
    if (enac) rdc <= mem[adrc];
  end

  z80_rom_bus_ctrl #(.WAIT_STATES(1)) u0 (
    .clk(clk), .rst(rst), .mreq_n(mreq_n), .rd_n(rd_n),
    .cpu_addr(cpu_addr), .rom_ena(ena0), .rom_addr(adr0),
    .rom_dout(rd0), .data_out(do0), .data_oe(oe0), .wait_n(wn0));

  z80_rom_bus_ctrl #(.WAIT_STATES(3)) u3 (
    .clk(clk), .rst(rst), .mreq_n(mreq_n), .rd_n(rd_n),
    .cpu_addr(cpu_addr), .rom_ena(ena3), .rom_addr(adr3),
    .rom_dout(rd3), .data_out(do3), .data_oe(oe3), .wait_n(wn3));

  z80_rom_bus_ctrl #(.WAIT_STATES(0)) uz (
    .clk(clk), .rst(rst), .mreq_n(mreq_n), .rd_n(rd_n),
    .cpu_addr(cpu_addr), .rom_ena(enaz), .rom_addr(adrz),
    .rom_dout(rdz), .data_out(doz), .data_oe(oez), .wait_n(wnz));

  z80_rom_bus_ctrl #(.WAIT_STATES(15)) uf (
    .clk(clk), .rst(rst), .mreq_n(mreq_n), .rd_n(rd_n),
    .cpu_addr(cpu_addr), .rom_ena(enaf), .rom_addr(adrf),
    .rom_dout(rdf), .data_out(dof), .data_oe(oef), .wait_n(wnf));

  z80_rom_bus_ctrl #(.BASE_ADDR(16'hC000), .WAIT_STATES(1)) uc (
    .clk(clk), .rst(rst), .mreq_n(mreq_n), .rd_n(rd_n),
    .cpu_addr(cpu_addr), .rom_ena(enac), .rom_addr(adrc),
    .rom_dout(rdc), .data_out(doc), .data_oe(oec), .wait_n(wnc));

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_rd(input logic [15:0] a);
    cpu_addr = a;
    mreq_n   = 1'b0;
    rd_n     = 1'b0;
  endtask

  task automatic bus_idle();
    mreq_n = 1'b1;
    rd_n   = 1'b1;
    step();
    step();
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'(i * 7 + 3);
    mem[14'h0123] = 8'hA5;
    mem[14'h0005] = 8'h37;
    mem[14'h0000] = 8'hC3;

    rst = 1'b1; mreq_n = 1'b1; rd_n = 1'b1; cpu_addr = 16'h0000;
    step();
    step();
    chk("rst ena", ena0, 0);
    chk("rst addr", adr0, 0);
    chk("rst dout", do0, 8'h00);
    chk("rst oe", oe0, 0);
    chk("rst wait", wn0, 1);
    rst = 1'b0;
    step();

    // one long read: u0/u3/uz/uf latencies 2+WS
    bus_rd(16'h0123);
    for (int k = 0; k <= 18; k++) begin
      step();
      chk("u0 ena", ena0, (k == 0));
      if (k == 0) chk("u0 addr", adr0, 14'h0123);
      chk("u0 wait", wn0, (k >= 3));
      chk("u0 oe", oe0, (k >= 3));
      chk("u0 data", do0, (k >= 3) ? 8'hA5 : 8'h00);
      chk("u3 oe", oe3, (k >= 5));
      chk("u3 wait", wn3, (k >= 5));
      chk("uz oe", oez, (k >= 2));
      chk("uz data", doz, (k >= 2) ? 8'hA5 : 8'h00);
      chk("uf oe", oef, (k >= 17));
      chk("uf wait", wnf, (k >= 17));
      chk("uf ena", enaf, (k == 0));
    end
    rd_n = 1'b1;
    step();
    chk("rel oe", oe0, 0);
    chk("rel data", do0, 8'hA5);
    chk("rel wait", wn0, 1);
    step();
    chk("rel idle", oe0, 0);
    bus_idle();

    // miss above the 16 KB window
    bus_rd(16'h4000);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("miss ena", ena0, 0);
      chk("miss wait", wn0, 1);
      chk("miss oe", oe0, 0);
    end
    bus_idle();

    // abort during stall, WS=3
    bus_rd(16'h0010);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("ab wait lo", wn3, 0);
      chk("ab oe lo", oe3, 0);
    end
    rd_n = 1'b1;
    step();
    chk("ab wait", wn3, 1);
    chk("ab oe", oe3, 0);
    chk("ab ena", ena3, 0);
    chk("ab data", do3, 8'hA5);
    step();
    chk("ab oe2", oe3, 0);
    bus_idle();

    // boot overlay, BASE 0xC000
    bus_rd(16'h0005);
    step();
`ifdef ROM_BOOT_OVERLAY_EN
    chk("ov1 ena", enac, 1);
    step(); step(); step();
    chk("ov1 oe", oec, 1);
    chk("ov1 data", doc, 8'h37);
`else
    chk("ov1 ena", enac, 0);
    step(); step(); step();
    chk("ov1 oe", oec, 0);
    chk("ov1 wait", wnc, 1);
`endif
    bus_idle();

    bus_rd(16'hC000);
    step();
    chk("ov2 ena", enac, 1);
    chk("ov2 addr", adrc, 0);
    step(); step(); step();
    chk("ov2 oe", oec, 1);
    chk("ov2 data", doc, 8'hC3);
    bus_idle();

    bus_rd(16'h0005);
    step();
    chk("ov3 ena", enac, 0);
    step(); step(); step();
    chk("ov3 oe", oec, 0);
    chk("ov3 wait", wnc, 1);
    bus_idle();

    // async reset in HOLD
    bus_rd(16'h0123);
    for (int k = 0; k < 4; k++) step();
    chk("pre oe", oe0, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar oe", oe0, 0);
    chk("ar wait", wn0, 1);
    chk("ar data", do0, 8'h00);
    chk("ar ena", ena0, 0);
    chk("ar addr", adr0, 0);
    mreq_n = 1'b1;
    rd_n   = 1'b1;
    step();
    rst = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
